// File: rtl/mac_pkg.sv
// mac_pkg: definitions shared across the MAC RX path.
//   - Ethertype constants for the L3 protocols the receive path knows about.
//   - State encoding of the ethertype demultiplexer.
package mac_pkg;

  localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } demux_state_e;

endpackage

// File: rtl/mac_type_match.sv
// mac_type_match: combinational ethertype lookup.
// Compares i_type against every 16-bit entry of i_table. When more than one
// entry matches, the lowest index wins.
// Ports:
//   i_type   ethertype under test
//   i_table  P_CH packed entries, entry k at [16k+15:16k]
//   o_hit    at least one entry matched
//   o_idx    index of the lowest matching entry (0 when no hit)
module mac_type_match #(
  parameter int P_CH    = 2,
  parameter int P_IDX_W = 1
) (
  input  logic [15:0]        i_type,
  input  logic [P_CH*16-1:0] i_table,
  output logic               o_hit,
  output logic [P_IDX_W-1:0] o_idx
);

  // Scan from the top down so a lower matching index overwrites a higher one.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int k = P_CH - 1; k >= 0; k--) begin
      if (i_table[k*16 +: 16] == i_type) begin
        o_hit = 1'b1;
        o_idx = P_IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mac_type_demux.sv
// mac_type_demux: routes MAC payload frames to one of P_CH channels by
// ethertype. The route is chosen on the first beat of a frame and held until
// its last beat. Unmatched frames go to P_DEFAULT_CH when P_DEFAULT_EN is set,
// otherwise they are discarded and counted. One cycle of latency, all outputs
// registered, no backpressure.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_pre_type        ethertype, looked at on the first valid beat only
//   i_pre_data        payload beat
//   i_pre_valid       beat valid
//   i_pre_last        last beat of frame (qualified by i_pre_valid)
//   o_ch_data         per-channel data, channel k at [k*P_DATA_W +: P_DATA_W]
//   o_ch_valid        per-channel valid (one-hot or zero)
//   o_ch_last         per-channel last
//   o_drop_pulse      one-cycle pulse per dropped frame
//   o_drop_cnt        saturating dropped-frame count
module mac_type_demux
  import mac_pkg::*;
#(
  parameter int                 P_CH         = 2,
  parameter int                 P_DATA_W     = 8,
  parameter logic [P_CH*16-1:0] P_TYPE_TABLE = {ETH_TYPE_ARP, ETH_TYPE_IP},
  parameter bit                 P_DEFAULT_EN = 1'b0,
  parameter int                 P_DEFAULT_CH = 0,
  parameter int                 P_CNT_W      = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [15:0]              i_pre_type,
  input  logic [P_DATA_W-1:0]      i_pre_data,
  input  logic                     i_pre_valid,
  input  logic                     i_pre_last,
  output logic [P_CH*P_DATA_W-1:0] o_ch_data,
  output logic [P_CH-1:0]          o_ch_valid,
  output logic [P_CH-1:0]          o_ch_last,
  output logic                     o_drop_pulse,
  output logic [P_CNT_W-1:0]       o_drop_cnt
);

  localparam int IDX_W = (P_CH > 1) ? $clog2(P_CH) : 1;
  localparam logic [IDX_W-1:0] DEF_CH = IDX_W'(P_DEFAULT_CH);

  function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] v);
    return (&v) ? v : v + P_CNT_W'(1);
  endfunction

  demux_state_e              state_q, state_d;
  logic [IDX_W-1:0]          sel_q, sel_d;
  logic [P_CH*P_DATA_W-1:0]  data_q, data_d;
  logic [P_CH-1:0]           valid_q, valid_d;
  logic [P_CH-1:0]           last_q, last_d;
  logic                      drop_pulse_q, drop_pulse_d;
  logic [P_CNT_W-1:0]        drop_cnt_q, drop_cnt_d;

  logic                      match_hit;
  logic [IDX_W-1:0]          match_idx;
  logic                      route_ok;
  logic [IDX_W-1:0]          route_ch;
  logic                      emit_en;
  logic [IDX_W-1:0]          emit_ch;

  mac_type_match #(
    .P_CH    (P_CH),
    .P_IDX_W (IDX_W)
  ) u_match (
    .i_type  (i_pre_type),
    .i_table (P_TYPE_TABLE),
    .o_hit   (match_hit),
    .o_idx   (match_idx)
  );

  // Candidate route for a first beat: table hit, else the default channel.
  always_comb begin
    route_ok = match_hit | P_DEFAULT_EN;
    route_ch = match_hit ? match_idx : DEF_CH;
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    drop_cnt_d   = drop_cnt_q;
    drop_pulse_d = 1'b0;
    emit_en      = 1'b0;
    emit_ch      = sel_q;
    valid_d      = '0;
    last_d       = '0;
    data_d       = '0;

    case (state_q)
      IDLE: begin
        if (i_pre_valid) begin
          if (route_ok) begin
            sel_d   = route_ch;
            emit_en = 1'b1;
            emit_ch = route_ch;
            state_d = i_pre_last ? IDLE : FWD;
          end else begin
            drop_pulse_d = 1'b1;
            drop_cnt_d   = sat_inc(drop_cnt_q);
            state_d      = i_pre_last ? IDLE : DROP;
          end
        end
      end
      // Type is deliberately ignored here: the route is fixed per frame.
      FWD: begin
        if (i_pre_valid) begin
          emit_en = 1'b1;
          emit_ch = sel_q;
          if (i_pre_last) state_d = IDLE;
        end
      end
      DROP: begin
        if (i_pre_valid && i_pre_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Steer the beat onto exactly one channel; idle channels carry zero data.
    for (int k = 0; k < P_CH; k++) begin
      if (emit_en && (emit_ch == IDX_W'(k))) begin
        valid_d[k]                      = 1'b1;
        last_d[k]                       = i_pre_last;
        data_d[k*P_DATA_W +: P_DATA_W]  = i_pre_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      data_q       <= '0;
      valid_q      <= '0;
      last_q       <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign o_ch_data    = data_q;
  assign o_ch_valid   = valid_q;
  assign o_ch_last    = last_q;
  assign o_drop_pulse = drop_pulse_q;
  assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: doc/mac_type_demux.md
Name: mac_type_demux

Overview:
- Parametrised successor of the two-way IP/ARP ethertype demultiplexer in the MAC RX path.
- Routes each MAC payload frame to one of P_CH output channels by matching i_pre_type against a parameter table.
- The routing decision is made once, on the first beat of the frame, and held for the whole frame.
- Unmatched frames go to an optional default channel or are dropped and counted.
- Sits between the MAC RX deframer and the IP/ARP/other L3 receivers.

Parameters:
- P_CH, 2, number of output channels (1..8).
- P_DATA_W, 8, data beat width in bits.
- P_TYPE_TABLE, {16'h0806,16'h0800}, P_CH×16-bit ethertype table; channel k uses bits [16k+15:16k]. Default: ch0 = IP 0x0800, ch1 = ARP 0x0806.
- P_DEFAULT_EN, 0, 1 = unmatched frames go to P_DEFAULT_CH; 0 = unmatched frames are dropped.
- P_DEFAULT_CH, 0, channel index used when P_DEFAULT_EN=1.
- P_CNT_W, 16, width of the drop counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_pre_type  in  16  ethertype of the current frame; sampled on the first valid beat only.
- i_pre_data  in  P_DATA_W  payload beat.
- i_pre_valid  in  1  beat valid.
- i_pre_last  in  1  last beat of frame; qualified by i_pre_valid.
- o_ch_data  out  P_CH×P_DATA_W  per-channel data; channel k at [k*P_DATA_W +: P_DATA_W].
- o_ch_valid  out  P_CH  per-channel valid.
- o_ch_last  out  P_CH  per-channel last.
- o_drop_pulse  out  1  one-cycle pulse per dropped frame.
- o_drop_cnt  out  P_CNT_W  saturating count of dropped frames.

Behaviour:
- Reset (async, i_rst=1): all outputs 0, state IDLE, latched channel select 0, drop counter 0.
- Latency: exactly 1 cycle, input beat to output beat. All outputs are registered.
- Output data is 0 on every channel whose valid is low. At most one o_ch_valid bit is high per cycle.
- No backpressure: every valid input beat is either forwarded or discarded in its own cycle.
- Match: compare i_pre_type with each table entry. The lowest matching index wins (covers duplicate entries). No match → default channel if P_DEFAULT_EN, else drop.

State machine, states IDLE / FWD / DROP:
- IDLE, i_pre_valid=0: stay; outputs idle.
- IDLE, i_pre_valid=1 and routed to channel k: latch sel=k; emit the beat on channel k next cycle. Next state is IDLE if i_pre_last, else FWD (single-beat frames are legal).
- IDLE, i_pre_valid=1 and dropped: pulse o_drop_pulse next cycle; o_drop_cnt+1, saturating at all-ones. Next state is IDLE if i_pre_last, else DROP.
- FWD: each valid beat goes to the latched sel. i_pre_type is ignored, even if it changes mid-frame. Valid gaps are allowed. On valid&last → IDLE.
- DROP: discard valid beats with no outputs. On valid&last → IDLE. The counter increments only once per frame.

Boundaries:
- Back-to-back frames with no gap: the beat after last is evaluated as a new first beat in IDLE. No bubble is inserted.
- Reset mid-frame: state returns to IDLE. Beats of the interrupted frame arriving after reset release are treated as a new frame start and their type is evaluated.
- i_pre_last with i_pre_valid=0 is ignored.
- Saturation: the counter holds at 2^P_CNT_W−1; o_drop_pulse still fires for each further dropped frame.

Decomposition:
- Shared package mac_pkg:
  - ethertype constants: ETH_TYPE_IP 16'h0800, ETH_TYPE_ARP 16'h0806, ETH_TYPE_IPV6 16'h86DD;
  - demux state encoding IDLE=2'd0, FWD=2'd1, DROP=2'd2.
- Sub-module mac_type_match: combinational table compare plus priority encoder. Inputs: type, table. Outputs: hit, index. Instantiated once.

Test Plan:
- Default params. A 46-beat frame with type 0x0800 (data 0x00..0x2D) → ch0 valid for 46 cycles starting 1 cycle after input, data identical, o_ch_last[0] on beat 46; ch1 silent.
- Type 0x0806, 28-beat frame with 3 valid gaps mid-frame → ch1 reproduces beats with the same gaps; last on beat 28.
- Type 0x86DD, 10 beats, P_DEFAULT_EN=0 → no channel valid, one o_drop_pulse, o_drop_cnt=1. Rerun with P_DEFAULT_EN=1, P_DEFAULT_CH=1 → all 10 beats on ch1, o_drop_cnt=0.
- Frame starting with type 0x0800, type switched to 0x0806 from beat 3 → all beats stay on ch0.
- Back-to-back frames IP(4 beats), ARP(1 beat, valid=last=1), IP(2 beats) with no idle cycles → channel switches on the exact beat boundaries with no lost beats.
- P_CNT_W=2: five unknown-type frames → o_drop_cnt 1,2,3,3,3 with 5 pulses. Then assert i_rst in the middle of an IP frame → all outputs 0 immediately; remaining beats after release are routed per their i_pre_type.
